// File: rtl/boolean_exp_sweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : boolexp_pkg
// Brief    : Shared state encoding and golden truth table for the sweeper.
// Revision : 1.0 - initial release
// ============================================================================
package boolexp_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Golden table for ABC + A'C' + D, bit i = OUT for vector i (A is MSB)
    localparam logic [15:0] REF_TT = 16'hEABB;

endpackage
`default_nettype wire

// File: rtl/boolean_exp_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module   : boolexp_sweep_if
// Brief    : Control/result bundle between a sweep requester and the sweeper.
// Revision : 1.0 - initial release
// ============================================================================
interface boolexp_sweep_if #(
    parameter int N_IN = 4
) ();

    localparam int TT_W = 2 ** N_IN;

    logic              start;
    logic [TT_W-1:0]   exp_table;
    logic              busy;
    logic              done;
    logic [TT_W-1:0]   truth_table;
    logic [N_IN:0]     ones_count;
    logic              mismatch;
    logic [N_IN-1:0]   fail_idx;

    modport master (
        output start, exp_table,
        input  busy, done, truth_table, ones_count, mismatch, fail_idx
    );

    modport slave (
        input  start, exp_table,
        output busy, done, truth_table, ones_count, mismatch, fail_idx
    );

endinterface
`default_nettype wire

// File: rtl/boolean_exp.sv
`default_nettype none
// ============================================================================
// Module   : boolean_exp
// Brief    : Combinational expression OUT = ABC + A'C' + D.
// Revision : 1.0 - initial release
// ============================================================================
module boolean_exp (
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic OUT
);

    assign OUT = (A & B & C) | (~A & ~C) | D;

endmodule
`default_nettype wire

// File: rtl/boolean_exp_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : boolean_exp_sweeper
// Brief    : Drives every input vector in order, captures OUT, counts ones and
//            flags the first disagreement with an expected truth table.
// Revision : 1.0 - initial release
// ============================================================================
module boolean_exp_sweeper
    import boolexp_pkg::*;
#(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    boolexp_sweep_if.slave      bus,
    output logic [N_IN-1:0]     vec,
    input  logic                f_in
);

    localparam int              TT_W     = 2 ** N_IN;
    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [TT_W-1:0]   exp_q, exp_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic [N_IN:0]     ones_q, ones_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mm_q, mm_d;
    logic [N_IN-1:0]   fidx_q, fidx_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        exp_d   = exp_q;
        tt_d    = tt_q;
        ones_d  = ones_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mm_d    = mm_q;
        fidx_d  = fidx_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    exp_d   = bus.exp_table;
                    vec_d   = '0;
                    cnt_d   = '0;
                    tt_d    = '0;
                    ones_d  = '0;
                    mm_d    = 1'b0;
                    fidx_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                tt_d[vec_q] = f_in;
                ones_d      = ones_q + {{N_IN{1'b0}}, f_in};
                // Only the first disagreement is reported
                if ((f_in != exp_q[vec_q]) && !mm_q) begin
                    mm_d   = 1'b1;
                    fidx_d = vec_q;
                end
                if (&vec_q) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mm_q    <= 1'b0;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mm_q    <= mm_d;
            fidx_q  <= fidx_d;
        end
    end

    assign vec             = vec_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.truth_table = tt_q;
    assign bus.ones_count  = ones_q;
    assign bus.mismatch    = mm_q;
    assign bus.fail_idx    = fidx_q;

endmodule
`default_nettype wire

// File: tb/tb_boolean_exp_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_boolean_exp_sweeper
// Brief    : Table-driven, scoreboarded bench for two sweeper instances
//            (settle 1 and settle 3) each wired to a boolean_exp block.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boolean_exp_sweeper;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    boolexp_sweep_if #(.N_IN(4)) bus0 ();
    boolexp_sweep_if #(.N_IN(4)) bus1 ();

    logic [3:0] vec0, vec1;
    logic       f0, f1;

    boolean_exp_sweeper #(.N_IN(4), .SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .vec(vec0), .f_in(f0)
    );
    boolean_exp ex0 (.A(vec0[3]), .B(vec0[2]), .C(vec0[1]), .D(vec0[0]), .OUT(f0));

    boolean_exp_sweeper #(.N_IN(4), .SETTLE_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .vec(vec1), .f_in(f1)
    );
    boolean_exp ex1 (.A(vec1[3]), .B(vec1[2]), .C(vec1[1]), .D(vec1[0]), .OUT(f1));

    typedef struct {
        int          sel;
        logic [15:0] exp_table;
        logic [15:0] tt;
        logic [4:0]  ones;
        logic        mm;
        logic [3:0]  fidx;
        int          lat;
    } vec_t;

    vec_t tbl [6];
    vec_t sb [$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic snapshot(input int sel, output logic [15:0] tt, output logic [4:0] ones,
                            output logic mm, output logic [3:0] fidx, output logic busy,
                            output logic done, output logic [3:0] v);
        if (sel == 0) begin
            tt = bus0.truth_table; ones = bus0.ones_count; mm = bus0.mismatch;
            fidx = bus0.fail_idx; busy = bus0.busy; done = bus0.done; v = vec0;
        end else begin
            tt = bus1.truth_table; ones = bus1.ones_count; mm = bus1.mismatch;
            fidx = bus1.fail_idx; busy = bus1.busy; done = bus1.done; v = vec1;
        end
    endtask

    task automatic set_start(input int sel, input logic s, input logic [15:0] e);
        if (sel == 0) begin
            bus0.start = s; bus0.exp_table = e;
        end else begin
            bus1.start = s; bus1.exp_table = e;
        end
    endtask

    // extra_at > 0 injects a second start pulse that must be ignored
    task automatic run_sweep(input vec_t rec, input int extra_at);
        logic [15:0] tt;
        logic [4:0]  ones;
        logic        mm, busy, done;
        logic [3:0]  fidx, v;
        int          lat = -1;
        int          sc;
        int          expv;
        bit          vec_ok  = 1'b1;
        bit          busy_ok = 1'b1;
        vec_t        e;
        sc = (rec.sel == 0) ? 1 : 3;
        sb.push_back(rec);
        @(negedge clk);
        set_start(rec.sel, 1'b1, rec.exp_table);
        @(posedge clk); #1;
        set_start(rec.sel, 1'b0, rec.exp_table);
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            snapshot(rec.sel, tt, ones, mm, fidx, busy, done, v);
            if (done) begin
                lat = k;
                break;
            end
            expv = k / (sc + 1);
            if (expv > 15) expv = 15;
            if (v !== 4'(expv)) vec_ok = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (k == extra_at) set_start(rec.sel, 1'b1, 16'h0000);
            else if (k == extra_at + 1) set_start(rec.sel, 1'b0, 16'h0000);
        end
        e = sb.pop_front();
        check("latency", lat, e.lat);
        check("truth_table", tt, e.tt);
        check("ones_count", ones, e.ones);
        check("mismatch", mm, e.mm);
        check("fail_idx", fidx, e.fidx);
        check("busy_at_done", busy, 1'b0);
        check("vec_order", vec_ok, 1'b1);
        check("busy_during", busy_ok, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        snapshot(rec.sel, tt, ones, mm, fidx, busy, done, v);
        check("tt_hold", tt, e.tt);
        check("ones_hold", ones, e.ones);
        check("done_pulse_width", done, 1'b0);
        check("vec_hold", v, 4'hF);
    endtask

    initial begin
        logic [15:0] tt;
        logic [4:0]  ones;
        logic        mm, busy, done;
        logic [3:0]  fidx, v;
        bit          hit;
        bit          done_seen;

        tbl[0] = '{0, 16'hEABB, 16'hEABB, 5'd11, 1'b0, 4'd0,  33};
        tbl[1] = '{0, 16'hEABA, 16'hEABB, 5'd11, 1'b1, 4'd0,  33};
        tbl[2] = '{0, 16'h0000, 16'hEABB, 5'd11, 1'b1, 4'd0,  33};
        tbl[3] = '{0, 16'hFFFF, 16'hEABB, 5'd11, 1'b1, 4'd2,  33};
        tbl[4] = '{0, 16'h6ABB, 16'hEABB, 5'd11, 1'b1, 4'd15, 33};
        tbl[5] = '{1, 16'hEABB, 16'hEABB, 5'd11, 1'b0, 4'd0,  65};

        rst = 1'b1;
        set_start(0, 1'b0, 16'h0000);
        set_start(1, 1'b0, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            snapshot(s, tt, ones, mm, fidx, busy, done, v);
            check("rst_tt", tt, 16'h0);
            check("rst_ones", ones, 5'd0);
            check("rst_mm", mm, 1'b0);
            check("rst_fidx", fidx, 4'd0);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_vec", v, 4'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_sweep(tbl[i], 0);
        end

        run_sweep(tbl[0], 10);

        // Abort a sweep partway through with an asynchronous reset
        @(negedge clk);
        set_start(0, 1'b1, 16'h0000);
        @(posedge clk); #1;
        set_start(0, 1'b0, 16'h0000);
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (vec0 == 4'd7) begin
                hit = 1'b1;
                break;
            end
        end
        check("reach_vec7", hit, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        snapshot(0, tt, ones, mm, fidx, busy, done, v);
        check("abort_tt", tt, 16'h0);
        check("abort_ones", ones, 5'd0);
        check("abort_mm", mm, 1'b0);
        check("abort_fidx", fidx, 4'd0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_vec", v, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus0.done || bus0.busy) done_seen = 1'b1;
        end
        check("no_done_after_abort", done_seen, 1'b0);

        run_sweep(tbl[0], 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
